// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter: owner encoding,
// access width codes, ROM region select bit and the alignment rule.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  localparam int ROM_SEL_BIT = 10;

  // Width code 2'b11 has no legal alignment and is always rejected.
  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
    logic bad;
    unique case (width)
      WIDTH_BYTE: bad = 1'b0;
      WIDTH_HALF: bad = addr_lo[0];
      WIDTH_WORD: bad = (addr_lo != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive cycles in which a pending fetch is denied; flags
// starvation once the count reaches STARVE_MAX so the next conflict goes to fetch.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic i_grant,
  output logic starved
);

  localparam int CNT_W = $clog2(STARVE_MAX + 2);

  logic [CNT_W-1:0] cnt_p1;

  assign starved = (cnt_p1 >= CNT_W'(STARVE_MAX));

  // Saturates at STARVE_MAX; a starved fetch is always granted next cycle anyway.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_p1 <= '0;
    end else if (!i_req || i_grant) begin
      cnt_p1 <= '0;
    end else if (!starved) begin
      cnt_p1 <= cnt_p1 + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data ports onto one single-port memory with
// 1-cycle synchronous read; one acceptance per cycle, response the cycle after.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_ready,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_data,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [1:0]        d_width,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_valid,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_write,
  output logic [1:0]        mem_width,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  owner_e owner_p1, owner_nxt;
  logic   err_p1, wr_p1;
  logic   starved, i_grant, d_grant, d_bad;

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (i_req),
    .i_grant(i_grant),
    .starved(starved)
  );

  // Data wins conflicts unless the fetch side has been starved.
  always_comb begin
    d_bad   = misaligned(d_width, d_address[1:0]) || (d_write && !d_address[ROM_SEL_BIT]);
    d_grant = rst_n && d_req && !(i_req && starved);
    i_grant = rst_n && i_req && !d_grant;
  end

  // ---- stage p0 -> p1: record who owns the response of this acceptance ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_p1 <= OWN_NONE;
      err_p1   <= 1'b0;
      wr_p1    <= 1'b0;
    end else begin
      owner_p1 <= owner_nxt;
      err_p1   <= d_bad;
      wr_p1    <= d_write;
    end
  end

  always_comb begin
    owner_nxt = OWN_NONE;
    if (i_grant) begin
      owner_nxt = OWN_INST;
    end else if (d_grant) begin
      owner_nxt = OWN_DATA;
    end
  end

  always_comb begin
    i_ready     = i_grant;
    d_ready     = d_grant;
    mem_en      = 1'b0;
    mem_write   = 1'b0;
    mem_width   = 2'b00;
    mem_address = '0;
    mem_wdata   = '0;
    if (i_grant) begin
      mem_en      = 1'b1;
      mem_width   = WIDTH_WORD;
      mem_address = i_address;
    end else if (d_grant && !d_bad) begin
      mem_en      = 1'b1;
      mem_write   = d_write;
      mem_width   = d_width;
      mem_address = d_address;
      mem_wdata   = d_wdata;
    end

    // Responses are masked during reset so an in-flight access never surfaces.
    i_valid = rst_n && (owner_p1 == OWN_INST);
    d_valid = rst_n && (owner_p1 == OWN_DATA);
    d_err   = d_valid && err_p1;
    i_data  = i_valid ? mem_rdata : '0;
    d_rdata = (d_valid && !err_p1 && !wr_p1) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_req = 1'b0;
  logic [ADDR_W-1:0] i_address = '0;
  logic              i_ready, i_valid;
  logic [DATA_W-1:0] i_data;
  logic              d_req = 1'b0, d_write = 1'b0;
  logic [1:0]        d_width = 2'b00;
  logic [ADDR_W-1:0] d_address = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_ready, d_valid, d_err;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en, mem_write;
  logic [1:0]        mem_width;
  logic [ADDR_W-1:0] mem_address, mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_address(i_address), .i_ready(i_ready), .i_valid(i_valid), .i_data(i_data),
    .d_req(d_req), .d_write(d_write), .d_width(d_width), .d_address(d_address), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_valid(d_valid), .d_err(d_err), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_write(mem_write), .mem_width(mem_width), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory environment: 1-cycle synchronous read, junk on the bus when idle.
  logic [31:0] tb_mem  [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_write) begin
      tb_mem[mem_address] = mem_wdata;
      mem_rdata <= $urandom;
    end else if (mem_en) begin
      mem_rdata <= tb_mem.exists(mem_address) ? tb_mem[mem_address] : mem_init(mem_address);
    end else begin
      mem_rdata <= $urandom;
    end
  end

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    tb_mem[a]  = v;
    ref_mem[a] = v;
  endtask

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Requester-side held requests and reset level.
  logic        rst_s = 1'b0;
  logic        i_pend = 1'b0;
  logic [31:0] i_addr_s = '0;
  logic        d_pend = 1'b0, d_wr_s = 1'b0;
  logic [1:0]  d_width_s = 2'b00;
  logic [31:0] d_addr_s = '0, d_wdata_s = '0;

  // Reference model state: response owed next cycle and fetch starvation count.
  int          p_own = 0;   // 0 none, 1 fetch, 2 data
  logic        p_err = 1'b0, p_wr = 1'b0;
  logic [31:0] p_data = '0;
  int          starve = 0;
  logic        obs_ir, obs_dr;

  task automatic req_i(input logic [31:0] a);
    i_pend = 1'b1; i_addr_s = a;
  endtask

  task automatic req_d(input logic wr, input logic [1:0] w, input logic [31:0] a, input logic [31:0] wd);
    d_pend = 1'b1; d_wr_s = wr; d_width_s = w; d_addr_s = a; d_wdata_s = wd;
  endtask

  task automatic step();
    logic e_ir, e_dr, e_en, e_wr, e_iv, e_dv, e_de, g_i, g_d, bad;
    logic [1:0]  e_w;
    logic [31:0] e_a, e_wd, e_id, e_dd;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = rst_s; i_req = i_pend; i_address = i_addr_s; d_req = d_pend;
    if (d_pend) begin
      d_write = d_wr_s; d_width = d_width_s; d_address = d_addr_s; d_wdata = d_wdata_s;
    end else begin
      d_write = 1'($urandom); d_width = 2'($urandom); d_address = $urandom; d_wdata = $urandom;
    end
    #1;
    {e_ir, e_dr, e_en, e_wr, e_iv, e_dv, e_de, g_i, g_d} = '0;
    e_w = 2'b00; e_a = '0; e_wd = '0; e_id = '0; e_dd = '0;
    bad = (d_width_s == 2'd3) || (d_width_s == 2'd2 && d_addr_s[1:0] != 2'd0) ||
          (d_width_s == 2'd1 && d_addr_s[0]) || (d_wr_s && !d_addr_s[10]);
    if (rst_s) begin
      if (d_pend && !(i_pend && starve >= STARVE_MAX)) g_d = 1'b1;
      else if (i_pend) g_i = 1'b1;
      e_ir = g_i; e_dr = g_d;
      if (g_i) begin
        e_en = 1'b1; e_w = 2'd2; e_a = i_addr_s;
      end else if (g_d && !bad) begin
        e_en = 1'b1; e_wr = d_wr_s; e_w = d_width_s; e_a = d_addr_s; e_wd = d_wdata_s;
      end
      e_iv = (p_own == 1);
      e_id = e_iv ? p_data : '0;
      e_dv = (p_own == 2);
      e_de = e_dv && p_err;
      e_dd = (e_dv && !p_err && !p_wr) ? p_data : '0;
    end
    chk("i_ready", i_ready, e_ir);       chk("d_ready", d_ready, e_dr);
    chk("mem_en", mem_en, e_en);         chk("mem_write", mem_write, e_wr);
    chk("mem_width", mem_width, e_w);    chk("mem_address", mem_address, e_a);
    chk("mem_wdata", mem_wdata, e_wd);   chk("i_valid", i_valid, e_iv);
    chk("i_data", i_data, e_id);         chk("d_valid", d_valid, e_dv);
    chk("d_err", d_err, e_de);           chk("d_rdata", d_rdata, e_dd);
    obs_ir = i_ready; obs_dr = d_ready;
    if (!rst_s) begin
      p_own = 0; starve = 0;
    end else begin
      p_own = g_i ? 1 : (g_d ? 2 : 0);
      p_err = bad; p_wr = d_wr_s;
      if (g_i) p_data = ref_rd(i_addr_s);
      else if (g_d && !bad && !d_wr_s) p_data = ref_rd(d_addr_s);
      if (g_d && !bad && d_wr_s) ref_mem[d_addr_s] = d_wdata_s;
      starve = (g_i || !i_pend) ? 0 : starve + 1;
      if (g_i) i_pend = 1'b0;
      if (g_d) d_pend = 1'b0;
    end
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((i_pend || d_pend) && n < max_cycles) begin
      step(); n++;
    end
    chk("drain_timeout", {i_pend, d_pend}, 2'b00);
    step(); step();
  endtask

  initial begin
    int first_i;
    preload(32'h0000_0004, 32'h0000_0013);

    // Requests held during reset must not be accepted.
    req_i(32'h0000_0004);
    rst_s = 1'b0;
    repeat (3) step();
    rst_s = 1'b1;
    step();
    chk("fetch_accept", obs_ir, 1'b1);
    step();
    chk("fetch_data", i_data, 32'h13);

    // Conflict: data first, fetch next, responses in grant order.
    req_i(32'h0000_0008);
    req_d(1'b0, 2'b10, 32'h0000_0400, 32'h0);
    step();
    chk("conflict_data_first", {obs_ir, obs_dr}, 2'b01);
    drain(4);

    // Continuous data pressure: fetch forced on the 5th conflict cycle.
    req_i(32'h0000_0020);
    first_i = 0;
    for (int k = 1; k <= 8 && i_pend; k++) begin
      if (!d_pend) req_d(1'b0, 2'b10, 32'h0000_0500 + 32'(4 * k), 32'h0);
      step();
      if (obs_ir && first_i == 0) first_i = k;
    end
    chk("starve_cycle", first_i, 5);
    req_i(32'h0000_0024);
    if (!d_pend) req_d(1'b0, 2'b10, 32'h0000_0600, 32'h0);
    step();
    chk("starve_cleared", {obs_ir, obs_dr}, 2'b01);
    drain(4);

    // Rejected accesses: misaligned RAM write and aligned write into ROM.
    req_d(1'b1, 2'b10, 32'h0000_0402, 32'h1111_1111);
    drain(2);
    req_d(1'b1, 2'b10, 32'h0000_0010, 32'h2222_2222);
    drain(2);
    req_d(1'b0, 2'b11, 32'h0000_0408, 32'h0);
    drain(2);

    // Write then read back-to-back.
    req_d(1'b1, 2'b10, 32'h0000_0404, 32'hDEAD_BEEF);
    step();
    req_d(1'b0, 2'b10, 32'h0000_0404, 32'h0);
    step();
    step();
    chk("readback", d_rdata, 32'hDEAD_BEEF);
    step();

    // Reset the cycle after a fetch grant: response is dropped.
    req_i(32'h0000_0004);
    step();
    rst_s = 1'b0;
    step();
    step();
    rst_s = 1'b1;
    step();
    chk("post_reset_idle", i_valid, 1'b0);
    req_i(32'h0000_0004);
    drain(2);

    // Random traffic.
    for (int t = 0; t < 3000; t++) begin
      rst_s = ($urandom_range(0, 99) != 0);
      if (!i_pend && $urandom_range(0, 1) == 1) req_i(32'($urandom_range(0, 511)) << 2);
      if (!d_pend && $urandom_range(0, 1) == 1)
        req_d(1'($urandom), 2'($urandom), 32'($urandom_range(0, 2047)), $urandom);
      step();
    end
    rst_s = 1'b1;
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
